imm_gen_stage: RTL and testbench

- Registered, parametrised immediate generator for the RV decode stage; successor of the combinational sign_extend.
- Takes instr[31:7] plus a format select and produces an XLEN-wide immediate one cycle later.
- Uses a valid/ready handshake with back-pressure, supports pipeline flush, adds CSR-zimm and shift-amount formats, and flags illegal selects.
- Sits between the instruction register and the ID/EX pipeline register.

---
 rtl/imm_pkg.sv | 17 +
 rtl/imm_decode.sv | 47 ++++
 rtl/imm_gen_stage.sv | 64 ++++++
 tb/tb_imm_gen_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants for the decode-stage immediate generator: format selects
// and the width of the instruction slice it consumes.
package imm_pkg;

    localparam int SEL_W   = 3;
    localparam int INSTR_W = 25;

    localparam logic [SEL_W-1:0] IMM_I   = 3'd0;
    localparam logic [SEL_W-1:0] IMM_S   = 3'd1;
    localparam logic [SEL_W-1:0] IMM_B   = 3'd2;
    localparam logic [SEL_W-1:0] IMM_U   = 3'd3;
    localparam logic [SEL_W-1:0] IMM_J   = 3'd4;
    localparam logic [SEL_W-1:0] IMM_Z   = 3'd5;
    localparam logic [SEL_W-1:0] IMM_SH  = 3'd6;
    localparam logic [SEL_W-1:0] IMM_ILL = 3'd7;

endpackage

// File: rtl/imm_decode.sv
// Combinational format mux: reassembles the immediate scattered over
// instr[31:7] (d[k] = instr[k+7]) and extends it to XLEN.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INSTR_W-1:0] d,
    input  logic [SEL_W-1:0]   sel,
    output logic [XLEN-1:0]    imm,
    output logic               ill
);

    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;

    function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    // Every signed format is first widened to 32 bits, then once more to XLEN.
    assign imm_i = 32'($signed(d[24:13]));
    assign imm_s = 32'($signed({d[24:18], d[4:0]}));
    assign imm_b = 32'($signed({d[24], d[0], d[23:18], d[4:1], 1'b0}));
    assign imm_u = $signed({d[24:5], 12'b0});
    assign imm_j = 32'($signed({d[24], d[12:5], d[13], d[23:14], 1'b0}));

    always_comb begin
        imm = '0;
        ill = 1'b0;
        case (sel)
            IMM_I:   imm = sext(imm_i);
            IMM_S:   imm = sext(imm_s);
            IMM_B:   imm = sext(imm_b);
            IMM_U:   imm = sext(imm_u);
            IMM_J:   imm = sext(imm_j);
            IMM_Z:   imm = XLEN'(d[12:8]);
            IMM_SH:  imm = (XLEN == 64) ? XLEN'(d[18:13]) : XLEN'(d[17:13]);
            IMM_ILL: ill = 1'b1;
            default: ill = 1'b0;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator between the instruction register and ID/EX:
// one-entry valid/ready stage around imm_decode, with flush and error flag.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SEL_W = imm_pkg::SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_data,
    input  logic [SEL_W-1:0]   in_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_imm,
    output logic               out_err
);

    logic [XLEN-1:0] dec_imm_p0;
    logic            dec_ill_p0;
    logic            accept_p0;

    logic            vld_p1;
    logic [XLEN-1:0] imm_p1;
    logic            err_p1;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .d   (in_data),
        .sel (in_sel),
        .imm (dec_imm_p0),
        .ill (dec_ill_p0)
    );

    // Ready depends only on flush and the output side, never on in_valid.
    assign in_ready  = !flush && (!vld_p1 || out_ready);
    assign accept_p0 = in_valid && in_ready;

    // p0 -> p1: decoded word captured on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            imm_p1 <= '0;
            err_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1 <= 1'b1;
            imm_p1 <= dec_imm_p0;
            err_p1 <= dec_ill_p0;
        end else if (vld_p1 && out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_imm   = imm_p1;
    assign out_err   = err_p1;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share
// stimulus; expectations come from an instruction-field reference model.
module tb_imm_gen_stage;

    typedef struct packed {
        logic [63:0] imm;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [24:0] in_data = '0;
    logic [2:0]  in_sel = '0;

    logic        rdy32, rdy64, ov32, ov64, oe32, oe64;
    logic [31:0] oi32;
    logic [63:0] oi64;

    logic [63:0] act_imm [2];
    logic        act_vld [2];
    logic        act_err [2];
    logic        act_rdy [2];

    exp_t q [2][$];
    bit   pend [2];
    exp_t pend_exp [2];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy32), .in_data(in_data), .in_sel(in_sel),
        .out_valid(ov32), .out_ready(out_ready), .out_imm(oi32), .out_err(oe32)
    );

    imm_gen_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy64), .in_data(in_data), .in_sel(in_sel),
        .out_valid(ov64), .out_ready(out_ready), .out_imm(oi64), .out_err(oe64)
    );

    assign act_imm[0] = {32'b0, oi32};
    assign act_imm[1] = oi64;
    assign act_vld[0] = ov32;
    assign act_vld[1] = ov64;
    assign act_err[0] = oe32;
    assign act_err[1] = oe64;
    assign act_rdy[0] = rdy32;
    assign act_rdy[1] = rdy64;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    function automatic longint sx(input longint raw, input int n);
        return raw[n-1] ? raw - (longint'(1) << n) : raw;
    endfunction

    // Reference: rebuild the 32-bit instruction and pick fields by ISA layout.
    function automatic exp_t model(input logic [24:0] d, input logic [2:0] sel, input int xlen);
        logic [31:0] ins;
        longint      v;
        exp_t        e;
        ins   = {d, 7'b0};
        v     = 0;
        e.err = 1'b0;
        case (sel)
            3'd0: v = sx(longint'(ins[31:20]), 12);
            3'd1: v = sx(longint'({ins[31:25], ins[11:7]}), 12);
            3'd2: v = sx(longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
            3'd3: v = sx(longint'({ins[31:12], 12'b0}), 32);
            3'd4: v = sx(longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
            3'd5: v = longint'(ins[19:15]);
            3'd6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: begin
                v     = 0;
                e.err = 1'b1;
            end
        endcase
        e.imm = (xlen == 32) ? {32'b0, v[31:0]} : 64'(v);
        return e;
    endfunction

    // Monitor: sample mid-cycle, predict the coming edge from the model state.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend[0] = 1'b0;
            pend[1] = 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                exp_t  e;
                bit    mrdy;
                string p;
                p    = (s == 0) ? "x32" : "x64";
                mrdy = !flush && (q[s].size() == 0 || out_ready);
                chk({p, "_in_ready"}, 64'(act_rdy[s]), 64'(mrdy));
                chk({p, "_occupancy"}, 64'(act_vld[s]), 64'(q[s].size() != 0));
                if (pend[s]) begin
                    chk({p, "_latency_valid"}, 64'(act_vld[s]), 64'd1);
                    chk({p, "_latency_imm"}, act_imm[s], pend_exp[s].imm);
                    pend[s] = 1'b0;
                end
                if (q[s].size() > 0 && (flush || out_ready)) begin
                    e = q[s].pop_front();
                    if (!flush) begin
                        chk({p, "_imm"}, act_imm[s], e.imm);
                        chk({p, "_err"}, 64'(act_err[s]), 64'(e.err));
                    end
                end
                if (in_valid && mrdy) begin
                    e = model(in_data, in_sel, (s == 0) ? 32 : 64);
                    q[s].push_back(e);
                    pend[s]     = 1'b1;
                    pend_exp[s] = e;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] sel, input logic [24:0] d);
        in_valid = v;
        in_sel   = sel;
        in_data  = d;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid32"}, 64'(ov32), 64'd0);
        chk({name, "_imm32"}, 64'(oi32), 64'd0);
        chk({name, "_err32"}, 64'(oe32), 64'd0);
        chk({name, "_valid64"}, 64'(ov64), 64'd0);
        chk({name, "_imm64"}, oi64, 64'd0);
        chk({name, "_err64"}, 64'(oe64), 64'd0);
    endtask

    logic [24:0] dv [5] = '{25'b1010101111000000000000001, 25'b1010101000000000100011100,
                            25'b1010101000010000000011101, 25'b1010101111001101111000001,
                            25'b1100110111111010101100001};
    logic [31:0] held;
    logic [24:0] tmp;

    initial begin
        repeat (2) step();
        chk_zero("reset");
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // back-to-back I/S/B/U/J
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'(i), dv[i]);
            step();
        end
        drive(1'b0, 3'd0, '0);
        step();

        // back-pressure with a waiting word
        drive(1'b1, 3'd0, 25'($urandom));
        step();
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 25'($urandom));
        held = oi32;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ready", 64'(rdy32), 64'd0);
            chk("stall_hold", 64'(oi32), 64'(held));
        end
        out_ready = 1'b1;
        step();
        drive(1'b0, 3'd0, '0);
        step();

        // CSR uimm, illegal, then legal again
        tmp = 25'($urandom);
        tmp[12:8] = 5'b11111;
        drive(1'b1, 3'd5, tmp);
        step();
        drive(1'b1, 3'd7, 25'($urandom));
        step();
        drive(1'b1, 3'd0, 25'($urandom));
        step();

        // shift amount and U with negative upper
        tmp = 25'($urandom);
        tmp[18:13] = 6'b111111;
        drive(1'b1, 3'd6, tmp);
        step();
        tmp = 25'($urandom);
        tmp[24] = 1'b1;
        drive(1'b1, 3'd3, tmp);
        step();
        drive(1'b0, 3'd0, '0);
        step();

        // flush while holding a word and offering another
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 25'($urandom));
        step();
        drive(1'b1, 3'd1, 25'($urandom));
        flush = 1'b1;
        #1;
        chk("flush_ready", 64'(rdy32), 64'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 3'd0, '0);
        chk("flush_valid", 64'(ov32), 64'd0);
        out_ready = 1'b1;
        step();

        // asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        drive(1'b1, 3'd2, 25'($urandom));
        step();
        drive(1'b0, 3'd0, '0);
        step();
        #2;
        rst_n = 1'b0;
        q[0].delete();
        q[1].delete();
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 3'd4, 25'($urandom));
        step();
        drive(1'b0, 3'd0, '0);
        step();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_sel    = 3'($urandom);
            in_data   = 25'($urandom);
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 16) == 0;
            step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("drain32", 64'(q[0].size()), 64'd0);
        chk("drain64", 64'(q[1].size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
